l1_l2_cache_system: RTL and testbench
=====================================

Name: l1_l2_cache_system

Overview:
Two-level, single-word-line cache between one CPU request port and main memory. L1 is direct-mapped. L2 is 4-way set-associative with per-set FIFO replacement. Both levels are write-through, no-write-allocate. The block exposes hit/miss strobes and 32-bit hit/miss counters for each level.

Parameters:
- L1_LINES, 64, number of L1 direct-mapped lines (power of 2).
- L2_SETS, 256, number of L2 sets (power of 2).
- L2_WAYS, 4, L2 associativity (fixed at 4; FIFO pointer is 2 bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  one-cycle request strobe.
- cpu_write  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_write_data  in  32  write data.
- cpu_read_data  out  32  read result; holds its last value.
- L1_hit, L1_miss  out  1 each  one-cycle L1 lookup result strobes.
- L2_hit, L2_miss  out  1 each  one-cycle L2 lookup result strobes.
- L1_hit_count, L1_miss_count, L2_hit_count, L2_miss_count  out  32 each  lookup counters.
- mem_req_to_main  out  1  one-cycle memory request strobe.
- mem_write_to_main  out  1  1 = memory write; qualified by mem_req_to_main.
- mem_addr_to_main  out  32  memory address.
- mem_write_data_to_main  out  32  memory write data.
- mem_read_data_from_main  in  32  read data; valid two edges after the request edge (registered at the edge after the request).

Behaviour:
- Address split, L1: index = addr[7:2], tag = addr[31:8].
- Address split, L2: index = addr[9:2], tag = addr[31:10]. Example: 0x000, 0x400, 0x800, 0xC00 and 0x1000 all map to L2 set 0.
- Reset (async, low): all valid bits, FIFO pointers, counters, strobes, mem_* outputs and cpu_read_data go to 0; FSM goes to IDLE. Reset mid-transaction aborts the transaction with no memory side effects afterwards.
- FSM states: IDLE, L2_LOOKUP, MEM_WAIT, MEM_FILL.
- cpu_req is accepted only in IDLE. A cpu_req in any other state is ignored and not counted.
- E0 (accepting edge, IDLE): latch addr/write/data and perform the L1 lookup. Set exactly one of L1_hit/L1_miss for one cycle and increment the matching counter.
  - Read hit: cpu_read_data <= L1 data; stay in IDLE (1-cycle latency).
  - Write hit: update L1 data.
  - Any miss, or any write: go to L2_LOOKUP.
- E1 (L2_LOOKUP): perform the L2 lookup. Set exactly one of L2_hit/L2_miss for one cycle and increment the matching counter.
  - Read hit: refill the L1 line (valid, tag, data); cpu_read_data <= L2 data; go to IDLE. Data is visible after E1.
  - Read miss: mem_req_to_main = 1 and mem_write_to_main = 0 for the cycle after E1, with mem_addr_to_main = latched address; go to MEM_WAIT.
  - Write (hit or miss): update L2 data on a hit. mem_req_to_main = 1, mem_write_to_main = 1, mem_addr_to_main and mem_write_data_to_main = latched values for one cycle; go to IDLE.
  - No allocation on a write miss at either level.
- E2 (MEM_WAIT): go to MEM_FILL.
- E3 (MEM_FILL): capture mem_read_data_from_main.
  - Write the line into L2 way fifo_ptr[set]; fifo_ptr increments mod 4.
  - Fill the L1 line.
  - cpu_read_data <= captured data; go to IDLE.
- FIFO pointer advances only on L2 fills. A 5th distinct tag in a set evicts the oldest fill; hits do not change order.
- L1 replacement is direct overwrite. Evictions need no writeback (write-through).
- Counters are 32-bit, free-running, and wrap at 2^32-1 to 0.
- Strobes and mem_req_to_main are high for exactly one cycle per event.
- mem_addr_to_main and mem_write_data_to_main hold their last value when idle.

Decomposition:
- Package l1_l2_cache_pkg: address-field widths, index/tag slice constants, and the FSM state enum.
- One natural sub-module, l2_set_assoc_array: L2 tag/valid/data storage, 4-way compare, and FIFO pointers.
- L1 array and FSM stay in the top level.

Test Plan:
- After reset, read 0x0 with memory returning addr+0xA0000000 -> L1_miss, L2_miss, one memory read of 0x0, cpu_read_data = 0xA0000000 after E3; counters L1m = 1, L2m = 1.
- Read 0x0 again -> L1_hit at E0, cpu_read_data = 0xA0000000, no memory request; L1h = 1.
- Read 0x100 (L1 conflict with 0x0), then 0x0 -> second access L1_miss, L2_hit, cpu_read_data = 0xA0000000 after E1, no memory traffic.
- Write 0xDEADBEEF to 0x0 -> L1_hit, L2_hit, memory write of addr 0x0 with data 0xDEADBEEF; subsequent read 0x0 returns 0xDEADBEEF.
- Write 0xCAFEF00D to 0x200 -> L1_miss, L2_miss, memory write issued, no allocation; subsequent read 0x200 misses both levels.
- Reads 0x400, 0x800, 0xC00, 0x1000 after 0x0 is in L2 -> next read of 0x0 gives L2_miss (FIFO evicted way 0), while a read of 0x400 still hits L2.
- Pulse cpu_req during MEM_WAIT -> request ignored, counters unchanged.
- Assert reset mid-miss -> all outputs return to 0.

Source files
------------

// File: rtl/l1_l2_cache_pkg.sv
// ============================================================================
// Module : l1_l2_cache_pkg
// Brief  : Shared widths, address-slice constants and FSM states for the
//          two-level write-through cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package l1_l2_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WORD_OFF = 2;
    localparam int WORD_W   = ADDR_W - WORD_OFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_L2_LOOKUP = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_MEM_FILL  = 2'd3
    } cache_state_t;

endpackage

`default_nettype wire

// File: rtl/l2_set_assoc_array.sv
// ============================================================================
// Module : l2_set_assoc_array
// Brief  : L2 tag/valid/data storage with way compare and per-set FIFO fill.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module l2_set_assoc_array
    import l1_l2_cache_pkg::*;
#(
    parameter int L2_SETS = 256,
    parameter int L2_WAYS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] i_word_addr,
    input  logic              i_wr_hit,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_fill,
    input  logic [DATA_W-1:0] i_fill_data,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int SET_W = $clog2(L2_SETS);
    localparam int TAG_W = WORD_W - SET_W;
    localparam int WAY_W = $clog2(L2_WAYS);

    logic [L2_WAYS-1:0] r_valid    [L2_SETS];
    logic [WAY_W-1:0]   r_fifo_ptr [L2_SETS];
    logic [TAG_W-1:0]   r_tag      [L2_SETS][L2_WAYS];
    logic [DATA_W-1:0]  r_data     [L2_SETS][L2_WAYS];

    logic [SET_W-1:0]   w_set;
    logic [TAG_W-1:0]   w_tag;
    logic [L2_WAYS-1:0] w_hit_vec;
    logic [WAY_W-1:0]   w_hit_way;

    assign w_set = i_word_addr[SET_W-1:0];
    assign w_tag = i_word_addr[WORD_W-1:SET_W];

    // A tag is only ever filled after a miss, so at most one way matches.
    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < L2_WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_set][w] && (r_tag[w_set][w] == w_tag);
            if (w_hit_vec[w]) begin
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign o_hit     = |w_hit_vec;
    assign o_rd_data = r_data[w_set][w_hit_way];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < L2_SETS; s++) begin
                r_valid[s]    <= '0;
                r_fifo_ptr[s] <= '0;
            end
        end else if (i_fill) begin
            r_valid[w_set][r_fifo_ptr[w_set]] <= 1'b1;
            r_fifo_ptr[w_set]                 <= r_fifo_ptr[w_set] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag[w_set][r_fifo_ptr[w_set]]  <= w_tag;
            r_data[w_set][r_fifo_ptr[w_set]] <= i_fill_data;
        end else if (i_wr_hit) begin
            r_data[w_set][w_hit_way] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l1_l2_cache_system.sv
// ============================================================================
// Module : l1_l2_cache_system
// Brief  : Direct-mapped L1 over 4-way FIFO L2, write-through, no-write-allocate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module l1_l2_cache_system
    import l1_l2_cache_pkg::*;
#(
    parameter int L1_LINES = 64,
    parameter int L2_SETS  = 256,
    parameter int L2_WAYS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        L1_hit,
    output logic        L1_miss,
    output logic        L2_hit,
    output logic        L2_miss,
    output logic [31:0] L1_hit_count,
    output logic [31:0] L1_miss_count,
    output logic [31:0] L2_hit_count,
    output logic [31:0] L2_miss_count,
    output logic        mem_req_to_main,
    output logic        mem_write_to_main,
    output logic [31:0] mem_addr_to_main,
    output logic [31:0] mem_write_data_to_main,
    input  logic [31:0] mem_read_data_from_main
);

    localparam int L1_IDX_W = $clog2(L1_LINES);
    localparam int L1_TAG_W = ADDR_W - WORD_OFF - L1_IDX_W;

    cache_state_t r_state, w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [L1_LINES-1:0] r_l1_valid;
    logic [L1_TAG_W-1:0] r_l1_tag  [L1_LINES];
    logic [DATA_W-1:0]   r_l1_data [L1_LINES];

    logic [DATA_W-1:0] r_rd_data;
    logic              r_l1_hit_p, r_l1_miss_p, r_l2_hit_p, r_l2_miss_p;
    logic [31:0]       r_l1_hit_cnt, r_l1_miss_cnt, r_l2_hit_cnt, r_l2_miss_cnt;
    logic              r_mem_req, r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [L1_IDX_W-1:0] w_cpu_idx, w_req_idx;
    logic [L1_TAG_W-1:0] w_cpu_tag, w_req_tag;
    logic                w_l1_hit, w_l2_hit;
    logic [DATA_W-1:0]   w_l2_rd_data;

    logic w_accept, w_l1_hit_ev, w_l1_miss_ev, w_l2_hit_ev, w_l2_miss_ev;
    logic w_rd_from_l1, w_l1_wr_hit, w_fill_from_l2, w_fill_from_mem;
    logic w_l2_wr_hit, w_mem_rd, w_mem_wr;

    assign w_cpu_idx = cpu_addr[WORD_OFF +: L1_IDX_W];
    assign w_cpu_tag = cpu_addr[ADDR_W-1 -: L1_TAG_W];
    assign w_req_idx = r_addr[WORD_OFF +: L1_IDX_W];
    assign w_req_tag = r_addr[ADDR_W-1 -: L1_TAG_W];
    assign w_l1_hit  = r_l1_valid[w_cpu_idx] && (r_l1_tag[w_cpu_idx] == w_cpu_tag);

    l2_set_assoc_array #(
        .L2_SETS (L2_SETS),
        .L2_WAYS (L2_WAYS)
    ) u_l2 (
        .clk         (clk),
        .reset       (reset),
        .i_word_addr (r_addr[ADDR_W-1:WORD_OFF]),
        .i_wr_hit    (w_l2_wr_hit),
        .i_wr_data   (r_wdata),
        .i_fill      (w_fill_from_mem),
        .i_fill_data (mem_read_data_from_main),
        .o_hit       (w_l2_hit),
        .o_rd_data   (w_l2_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_l1_hit_ev     = 1'b0;
        w_l1_miss_ev    = 1'b0;
        w_l2_hit_ev     = 1'b0;
        w_l2_miss_ev    = 1'b0;
        w_rd_from_l1    = 1'b0;
        w_l1_wr_hit     = 1'b0;
        w_fill_from_l2  = 1'b0;
        w_fill_from_mem = 1'b0;
        w_l2_wr_hit     = 1'b0;
        w_mem_rd        = 1'b0;
        w_mem_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    w_accept     = 1'b1;
                    w_l1_hit_ev  = w_l1_hit;
                    w_l1_miss_ev = !w_l1_hit;
                    w_rd_from_l1 = w_l1_hit && !cpu_write;
                    w_l1_wr_hit  = w_l1_hit && cpu_write;
                    if (!w_l1_hit || cpu_write) begin
                        w_next_state = ST_L2_LOOKUP;
                    end
                end
            end
            ST_L2_LOOKUP: begin
                w_l2_hit_ev  = w_l2_hit;
                w_l2_miss_ev = !w_l2_hit;
                if (r_write) begin
                    w_l2_wr_hit  = w_l2_hit;
                    w_mem_wr     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_l2_hit) begin
                    w_fill_from_l2 = 1'b1;
                    w_next_state   = ST_IDLE;
                end else begin
                    w_mem_rd     = 1'b1;
                    w_next_state = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                w_next_state = ST_MEM_FILL;
            end
            ST_MEM_FILL: begin
                w_fill_from_mem = 1'b1;
                w_next_state    = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_l1_valid    <= '0;
            r_rd_data     <= '0;
            r_l1_hit_p    <= 1'b0;
            r_l1_miss_p   <= 1'b0;
            r_l2_hit_p    <= 1'b0;
            r_l2_miss_p   <= 1'b0;
            r_l1_hit_cnt  <= '0;
            r_l1_miss_cnt <= '0;
            r_l2_hit_cnt  <= '0;
            r_l2_miss_cnt <= '0;
            r_mem_req     <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_l1_hit_p  <= w_l1_hit_ev;
            r_l1_miss_p <= w_l1_miss_ev;
            r_l2_hit_p  <= w_l2_hit_ev;
            r_l2_miss_p <= w_l2_miss_ev;
            r_mem_req   <= w_mem_rd || w_mem_wr;
            if (w_l1_hit_ev)  r_l1_hit_cnt  <= r_l1_hit_cnt + 32'd1;
            if (w_l1_miss_ev) r_l1_miss_cnt <= r_l1_miss_cnt + 32'd1;
            if (w_l2_hit_ev)  r_l2_hit_cnt  <= r_l2_hit_cnt + 32'd1;
            if (w_l2_miss_ev) r_l2_miss_cnt <= r_l2_miss_cnt + 32'd1;
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_write <= cpu_write;
                r_wdata <= cpu_write_data;
            end
            if (w_mem_rd || w_mem_wr) begin
                r_mem_write <= w_mem_wr;
                r_mem_addr  <= r_addr;
            end
            if (w_mem_wr) begin
                r_mem_wdata <= r_wdata;
            end
            if (w_rd_from_l1) begin
                r_rd_data <= r_l1_data[w_cpu_idx];
            end else if (w_fill_from_l2) begin
                r_rd_data <= w_l2_rd_data;
            end else if (w_fill_from_mem) begin
                r_rd_data <= mem_read_data_from_main;
            end
            if (w_fill_from_l2 || w_fill_from_mem) begin
                r_l1_valid[w_req_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_l1_wr_hit) begin
            r_l1_data[w_cpu_idx] <= cpu_write_data;
        end else if (w_fill_from_l2) begin
            r_l1_tag[w_req_idx]  <= w_req_tag;
            r_l1_data[w_req_idx] <= w_l2_rd_data;
        end else if (w_fill_from_mem) begin
            r_l1_tag[w_req_idx]  <= w_req_tag;
            r_l1_data[w_req_idx] <= mem_read_data_from_main;
        end
    end

    assign cpu_read_data          = r_rd_data;
    assign L1_hit                 = r_l1_hit_p;
    assign L1_miss                = r_l1_miss_p;
    assign L2_hit                 = r_l2_hit_p;
    assign L2_miss                = r_l2_miss_p;
    assign L1_hit_count           = r_l1_hit_cnt;
    assign L1_miss_count          = r_l1_miss_cnt;
    assign L2_hit_count           = r_l2_hit_cnt;
    assign L2_miss_count          = r_l2_miss_cnt;
    assign mem_req_to_main        = r_mem_req;
    assign mem_write_to_main      = r_mem_write;
    assign mem_addr_to_main       = r_mem_addr;
    assign mem_write_data_to_main = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_l1_l2_cache_system.sv
// ============================================================================
// Module : tb_l1_l2_cache_system
// Brief  : Directed plus random accesses scored against a cache reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_l1_l2_cache_system;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        L1_hit, L1_miss, L2_hit, L2_miss;
    logic [31:0] L1_hit_count, L1_miss_count, L2_hit_count, L2_miss_count;
    logic        mem_req_to_main, mem_write_to_main;
    logic [31:0] mem_addr_to_main, mem_write_data_to_main;
    logic [31:0] r_mem_rdata = '0;

    l1_l2_cache_system dut (
        .clk                     (clk),
        .reset                   (reset),
        .cpu_req                 (cpu_req),
        .cpu_write               (cpu_write),
        .cpu_addr                (cpu_addr),
        .cpu_write_data          (cpu_write_data),
        .cpu_read_data           (cpu_read_data),
        .L1_hit                  (L1_hit),
        .L1_miss                 (L1_miss),
        .L2_hit                  (L2_hit),
        .L2_miss                 (L2_miss),
        .L1_hit_count            (L1_hit_count),
        .L1_miss_count           (L1_miss_count),
        .L2_hit_count            (L2_hit_count),
        .L2_miss_count           (L2_miss_count),
        .mem_req_to_main         (mem_req_to_main),
        .mem_write_to_main       (mem_write_to_main),
        .mem_addr_to_main        (mem_addr_to_main),
        .mem_write_data_to_main  (mem_write_data_to_main),
        .mem_read_data_from_main (r_mem_rdata)
    );

    always #5 clk = ~clk;

    // Main memory returns addr + 0xA0000000, registered at the edge after the request.
    always @(posedge clk) begin
        if (mem_req_to_main && !mem_write_to_main) begin
            r_mem_rdata <= mem_addr_to_main + 32'hA000_0000;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: L1 keyed by word address, L2 sets as oldest-first lists.
    logic        m_l1_v [64];
    logic [29:0] m_l1_a [64];
    logic [31:0] m_l1_d [64];
    logic [29:0] m_l2_a [256][4];
    logic [31:0] m_l2_d [256][4];
    int          m_l2_n [256];
    logic [31:0] m_rd;
    logic [31:0] e_l1h, e_l1m, e_l2h, e_l2m;

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_l1_v[i] = 1'b0;
        for (int i = 0; i < 256; i++) m_l2_n[i] = 0;
        m_rd  = '0;
        e_l1h = '0;
        e_l1m = '0;
        e_l2h = '0;
        e_l2m = '0;
    endtask

    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output bit l1hit, output bit l2look, output bit l2hit,
                                output bit memrd, output bit memwr, output int lat);
        logic [29:0] wa;
        int li, s, k;
        wa = a[31:2];
        li = int'(wa % 64);
        s  = int'(wa % 256);
        l2look = 0; l2hit = 0; memrd = 0; memwr = 0; lat = 4;
        l1hit = m_l1_v[li] && (m_l1_a[li] == wa);
        if (l1hit) e_l1h++; else e_l1m++;
        if (!w && l1hit) begin
            m_rd = m_l1_d[li];
            lat  = 1;
            return;
        end
        if (w && l1hit) m_l1_d[li] = d;
        l2look = 1;
        k = -1;
        for (int i = 0; i < m_l2_n[s]; i++) if (m_l2_a[s][i] == wa) k = i;
        l2hit = (k >= 0);
        if (l2hit) e_l2h++; else e_l2m++;
        if (w) begin
            if (l2hit) m_l2_d[s][k] = d;
            memwr = 1;
        end else if (l2hit) begin
            m_rd = m_l2_d[s][k];
            m_l1_v[li] = 1'b1; m_l1_a[li] = wa; m_l1_d[li] = m_rd;
            lat = 2;
        end else begin
            memrd = 1;
            m_rd  = {wa, 2'b00} + 32'hA000_0000;
            if (m_l2_n[s] == 4) begin
                for (int i = 0; i < 3; i++) begin
                    m_l2_a[s][i] = m_l2_a[s][i+1];
                    m_l2_d[s][i] = m_l2_d[s][i+1];
                end
                m_l2_n[s] = 3;
            end
            m_l2_a[s][m_l2_n[s]] = wa;
            m_l2_d[s][m_l2_n[s]] = m_rd;
            m_l2_n[s]++;
            m_l1_v[li] = 1'b1; m_l1_a[li] = wa; m_l1_d[li] = m_rd;
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input bit inject);
        bit          l1hit, l2look, l2hit, memrd, memwr;
        int          lat;
        int          c_l1h, c_l1m, c_l2h, c_l2m, n_req;
        logic        rq_w;
        logic [31:0] rq_a, rq_d, prev_rd;
        logic [31:0] rd_at [5];
        c_l1h = 0; c_l1m = 0; c_l2h = 0; c_l2m = 0; n_req = 0;
        rq_w = 1'b0; rq_a = '0; rq_d = '0;
        prev_rd = m_rd;
        model_access(w, a, d, l1hit, l2look, l2hit, memrd, memwr, lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_write_data = d;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            c_l1h += int'(L1_hit);
            c_l1m += int'(L1_miss);
            c_l2h += int'(L2_hit);
            c_l2m += int'(L2_miss);
            if (mem_req_to_main) begin
                n_req++;
                rq_w = mem_write_to_main;
                rq_a = mem_addr_to_main;
                rq_d = mem_write_data_to_main;
            end
            rd_at[k] = cpu_read_data;
            if (k == 1) cpu_req = 1'b0;
            if (inject && k == 2) begin
                cpu_req   = 1'b1;
                cpu_write = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom & 32'hFFFF_FFFC;
            end
            if (inject && k == 3) cpu_req = 1'b0;
        end
        check_eq("l1_hit_pulses",  32'(c_l1h), 32'(l1hit));
        check_eq("l1_miss_pulses", 32'(c_l1m), 32'(!l1hit));
        check_eq("l2_hit_pulses",  32'(c_l2h), 32'(l2hit));
        check_eq("l2_miss_pulses", 32'(c_l2m), 32'(l2look && !l2hit));
        check_eq("mem_req_pulses", 32'(n_req), 32'(memrd || memwr));
        if ((memrd || memwr) && n_req == 1) begin
            check_eq("mem_write_flag", 32'(rq_w), 32'(memwr));
            check_eq("mem_addr", rq_a, a);
            if (memwr) check_eq("mem_wdata", rq_d, d);
        end
        if (!w) begin
            check_eq("rd_data_at_latency", rd_at[lat], m_rd);
            if (lat > 1) check_eq("rd_data_early", rd_at[lat-1], prev_rd);
        end
        check_eq("rd_data_final", rd_at[4], m_rd);
        check_eq("l1_hit_count",  L1_hit_count,  e_l1h);
        check_eq("l1_miss_count", L1_miss_count, e_l1m);
        check_eq("l2_hit_count",  L2_hit_count,  e_l2h);
        check_eq("l2_miss_count", L2_miss_count, e_l2m);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_data"}, cpu_read_data, 32'h0);
        check_eq({tag, "_strobes"}, {28'h0, L1_hit, L1_miss, L2_hit, L2_miss}, 32'h0);
        check_eq({tag, "_counters"}, L1_hit_count | L1_miss_count | L2_hit_count | L2_miss_count, 32'h0);
        check_eq({tag, "_mem_ctl"}, {30'h0, mem_req_to_main, mem_write_to_main}, 32'h0);
        check_eq({tag, "_mem_addr"}, mem_addr_to_main, 32'h0);
        check_eq({tag, "_mem_wdata"}, mem_write_data_to_main, 32'h0);
    endtask

    function automatic logic [31:0] pool_addr();
        return (32'($urandom_range(0, 7)) << 10) | (32'($urandom_range(0, 3)) << 8) |
               (32'($urandom_range(0, 3)) << 2);
    endfunction

    initial begin
        int n_mid_req;
        reset = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_write_data = '0;
        model_clear();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        check_eq("first_read_value", cpu_read_data, 32'hA000_0000);
        access(1'b0, 32'h0000_0100, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        access(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        check_eq("read_after_write", cpu_read_data, 32'hDEAD_BEEF);
        access(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1'b0);
        access(1'b0, 32'h0000_0200, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0400, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0800, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0C00, 32'h0, 1'b0);
        access(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0400, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        access(1'b0, 32'h0000_2000, 32'h0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 3) == 0), pool_addr(), $urandom, 1'b0);
        end

        // Reset while a read miss has its memory request outstanding.
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_5000;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_mem_req", 32'(mem_req_to_main), 32'h1);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        n_mid_req = 0;
        repeat (3) begin
            @(negedge clk);
            n_mid_req += int'(mem_req_to_main);
        end
        check_eq("mem_req_during_reset", 32'(n_mid_req), 32'h0);
        reset = 1'b1;
        model_clear();

        for (int i = 0; i < 30; i++) begin
            access(1'($urandom_range(0, 3) == 0), pool_addr(), $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
